keypad_entry: RTL and testbench
===============================

KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clk cycles per row step (1 kHz row rate at 50 MHz).
REQ-002 SHALL have parameter DEBOUNCE, default 5, meaning consecutive identical frames needed to accept a press or a release.
REQ-003 SHALL have port clk  input  1  the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port key_row  output  4  keypad row drive; active-low, one-hot.
REQ-006 SHALL have port key_col  input  4  keypad column sense; active-low, externally pulled up.
REQ-007 SHALL have port key_code  output  4  code of the last accepted key.
REQ-008 SHALL have port key_strobe  output  1  one-cycle pulse when a key is accepted.
REQ-009 SHALL have port digit_cnt  output  2  count of digits currently entered (0-2).
REQ-010 SHALL have port value  output  7  last committed two-digit value, range 0-99, binary.
REQ-011 SHALL have port value_valid  output  1  one-cycle pulse when value is committed.

Function
REQ-012 Keymap SHALL be row0: 1 2 3 A; row1: 4 5 6 B; row2: 7 8 9 C; row3: * 0 # D, with col0 as the leftmost column.
REQ-013 key_code SHALL be 0-9 for digits, A-D = 10-13, * = 14, # = 15.
REQ-014 Scan SHALL drive rows 0,1,2,3 in turn, each for SCAN_DIV cycles, then wrap to row 0; one pass of 4 rows is a frame.
REQ-015 key_col SHALL be sampled only in the last cycle of each row period; the row advances on the following edge.
REQ-016 At frame end, each frame SHALL be classified as: NONE (no low column), SINGLE(code) (exactly one low bit across the frame), or MULTI (more than one); MULTI SHALL count as NONE.
REQ-017 The debounce FSM SHALL have states IDLE, PRESS_WAIT, HELD and REL_WAIT, with a frame counter.
REQ-018 In IDLE, a SINGLE frame SHALL go to PRESS_WAIT with count=1 and the candidate code latched.
REQ-019 In PRESS_WAIT, the same code SHALL increment count; a differing or NONE frame SHALL return to IDLE.
REQ-020 In PRESS_WAIT, reaching count=DEBOUNCE SHALL go to HELD, load key_code and pulse key_strobe for 1 cycle.
REQ-021 In HELD, a NONE frame SHALL go to REL_WAIT with count=1; SINGLE frames SHALL stay in HELD with no further strobe.
REQ-022 In REL_WAIT, a NONE frame SHALL increment count and reaching DEBOUNCE SHALL go to IDLE; any SINGLE frame SHALL return to HELD without a strobe.
REQ-023 Entry SHALL act on the cycle of key_strobe, with its effects visible on the next cycle.
REQ-024 On a digit d with digit_cnt<2, entry SHALL become entry*10+d and digit_cnt SHALL increment.
REQ-025 On a digit with digit_cnt=2, the digit SHALL be ignored.
REQ-026 On *, entry and digit_cnt SHALL be cleared; value SHALL be unchanged.
REQ-027 On # with digit_cnt>0, value SHALL take entry, value_valid SHALL pulse 1 cycle, and entry and digit_cnt SHALL be cleared.
REQ-028 On # with digit_cnt=0, there SHALL be no pulse and no change.
REQ-029 Keys A-D SHALL be ignored by entry but still strobe.
REQ-030 entry SHALL be a 7-bit register whose arithmetic never exceeds 99.
REQ-031 The scan SHALL never stall: it runs continuously regardless of FSM state.

Reset
REQ-032 While rst=1, the block SHALL set key_row=4'b1110, the row divider to 0, the FSM to IDLE with count=0, key_code=0, key_strobe=0, digit_cnt=0, entry=0, value=0 and value_valid=0.
REQ-033 rst asserted mid-scan or mid-debounce SHALL abort all progress; the first frame after release SHALL start at row 0.
REQ-034 Outputs SHALL hold their reset values in the first cycle after rst deasserts.

Verification (SCAN_DIV=4, DEBOUNCE=2)
REQ-035 Reset/scan: release rst -> key_row cycles 1110,1101,1011,0111 every 4 clk, then wraps to 1110.
REQ-036 Entry 4,2,#: press 4, then 2, then #, each held for 3 frames and released for 3 frames -> key_strobe pulses with codes 4, 2, 15; value=42 with value_valid pulsing once; digit_cnt goes 1, 2, 0.
REQ-037 Bounce: key 7 present for 1 frame, absent for 1, then present for 1 -> no strobe; holding it for 2 frames -> exactly one strobe with code 7.
REQ-038 Overflow/clear: 9,9,5,# -> value=99; then 3,*,# -> no value_valid and value stays 99.
REQ-039 Multi-key: 1 and 5 held together -> no strobe; releasing 5 while 1 stays held for 2 frames -> strobe with code 1.
REQ-040 Reset mid-press: rst during PRESS_WAIT with digit_cnt=1 -> digit_cnt=0, no strobe, key_row=1110.

Source files
------------

// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner with frame-level debounce and two-digit decimal entry.
// Rows are strobed continuously. Each complete frame is classified, debounced, and fed to the digit accumulator.
module keypad_entry #(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] key_row,
  input  logic [3:0] key_col,
  output logic [3:0] key_code,
  output logic       key_strobe,
  output logic [1:0] digit_cnt,
  output logic [6:0] value,
  output logic       value_valid
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} state_t;

  function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
    case ({row, col})
      4'h0: keymap = 4'd1;   4'h1: keymap = 4'd2;   4'h2: keymap = 4'd3;   4'h3: keymap = 4'd10;
      4'h4: keymap = 4'd4;   4'h5: keymap = 4'd5;   4'h6: keymap = 4'd6;   4'h7: keymap = 4'd11;
      4'h8: keymap = 4'd7;   4'h9: keymap = 4'd8;   4'hA: keymap = 4'd9;   4'hB: keymap = 4'd12;
      4'hC: keymap = 4'd14;  4'hD: keymap = 4'd0;   4'hE: keymap = 4'd15;  default: keymap = 4'd13;
    endcase
  endfunction

  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_row;
  logic [1:0]       r_acc_n;
  logic [3:0]       r_acc_code;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_cand;
  logic [3:0]       r_code;
  logic             r_strobe;
  logic [1:0]       r_digits;
  logic [6:0]       r_entry;
  logic [6:0]       r_value;
  logic             r_valid;

  logic             w_sample;
  logic             w_frame_end;
  logic [3:0]       w_low;
  logic [2:0]       w_row_n;
  logic [2:0]       w_sum;
  logic [1:0]       w_col;
  logic [1:0]       w_tot_n;
  logic [3:0]       w_tot_code;
  logic             w_single;
  logic [CNT_W-1:0] w_cnt_inc;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       w_cand_nxt;
  logic             w_accept;
  logic [6:0]       w_entry_mac;

  assign w_sample    = (r_div == DIV_LAST);
  assign w_frame_end = w_sample && (r_row == 2'd3);
  assign w_low       = ~key_col;
  assign w_row_n     = 3'(w_low[0]) + 3'(w_low[1]) + 3'(w_low[2]) + 3'(w_low[3]);
  assign w_sum       = {1'b0, r_acc_n} + w_row_n;
  assign w_tot_n     = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
  assign w_tot_code  = (w_row_n == 3'd1) ? keymap(r_row, w_col) : r_acc_code;
  assign w_single    = (w_tot_n == 2'd1);
  assign w_cnt_inc   = r_cnt + CNT_ONE;
  assign w_entry_mac = (r_entry * 7'd10) + {3'b000, r_code};

  always_comb begin
    w_col = 2'd0;
    if (w_low[0])      w_col = 2'd0;
    else if (w_low[1]) w_col = 2'd1;
    else if (w_low[2]) w_col = 2'd2;
    else if (w_low[3]) w_col = 2'd3;
  end

  // Scan: row divider plus per-frame low-column tally (saturating at 2 = multi)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div      <= '0;
      r_row      <= 2'd0;
      r_acc_n    <= 2'd0;
      r_acc_code <= 4'd0;
    end else if (w_sample) begin
      r_div <= '0;
      r_row <= r_row + 2'd1;
      if (w_frame_end) begin
        r_acc_n    <= 2'd0;
        r_acc_code <= 4'd0;
      end else begin
        r_acc_n    <= w_tot_n;
        r_acc_code <= w_tot_code;
      end
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign key_row = ~(4'b0001 << r_row);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_accept    = 1'b0;
    if (w_frame_end) begin
      case (r_state)
        IDLE: if (w_single) begin
          w_cand_nxt = w_tot_code;
          if (CNT_ONE == CNT_DONE) begin
            w_state_nxt = HELD;
            w_cnt_nxt   = '0;
            w_accept    = 1'b1;
          end else begin
            w_state_nxt = PRESS_WAIT;
            w_cnt_nxt   = CNT_ONE;
          end
        end
        PRESS_WAIT: if (w_single && (w_tot_code == r_cand)) begin
          if (w_cnt_inc == CNT_DONE) begin
            w_state_nxt = HELD;
            w_cnt_nxt   = '0;
            w_accept    = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end else begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
        HELD: if (!w_single) begin
          w_state_nxt = (CNT_ONE == CNT_DONE) ? IDLE : REL_WAIT;
          w_cnt_nxt   = (CNT_ONE == CNT_DONE) ? '0 : CNT_ONE;
        end
        REL_WAIT: if (w_single) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (w_cnt_inc == CNT_DONE) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_cand   <= 4'd0;
      r_code   <= 4'd0;
      r_strobe <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_cand   <= w_cand_nxt;
      r_strobe <= w_accept;
      if (w_accept) r_code <= w_cand_nxt;
    end
  end

  // Entry: acts on the strobe cycle; only digits 0-9 accumulate, at most two of them
  always_ff @(posedge clk) begin
    if (rst) begin
      r_digits <= 2'd0;
      r_entry  <= 7'd0;
      r_value  <= 7'd0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_strobe) begin
        if (r_code <= 4'd9) begin
          if (r_digits != 2'd2) begin
            r_entry  <= w_entry_mac;
            r_digits <= r_digits + 2'd1;
          end
        end else if (r_code == 4'd14) begin
          r_entry  <= 7'd0;
          r_digits <= 2'd0;
        end else if ((r_code == 4'd15) && (r_digits != 2'd0)) begin
          r_value  <= r_entry;
          r_valid  <= 1'b1;
          r_entry  <= 7'd0;
          r_digits <= 2'd0;
        end
      end
    end
  end

  assign key_code    = r_code;
  assign key_strobe  = r_strobe;
  assign digit_cnt   = r_digits;
  assign value       = r_value;
  assign value_valid = r_valid;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: an ideal keypad driven frame by frame, with a key-level behavioural model
// of debounce and decimal entry predicting strobes, committed values and digit counts.
module tb_keypad_entry;
  localparam int SD    = 4;
  localparam int DEB   = 2;
  localparam int FRAME = 4 * SD;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic [3:0] key_code;
  logic       key_strobe;
  logic [1:0] digit_cnt;
  logic [6:0] value;
  logic       value_valid;
  logic [15:0] mask;

  int n_checks = 0;
  int n_fail   = 0;

  int got_strobe[$];
  int exp_strobe[$];
  int got_vv[$];
  int exp_vv[$];

  int m_pressed, m_streak, m_cand, m_keycode, m_digits, m_entry, m_value;
  bit last_acc;

  keypad_entry #(.SCAN_DIV(SD), .DEBOUNCE(DEB)) dut (
    .clk(clk), .rst(rst), .key_row(key_row), .key_col(key_col),
    .key_code(key_code), .key_strobe(key_strobe), .digit_cnt(digit_cnt),
    .value(value), .value_valid(value_valid)
  );

  always #5 clk = ~clk;

  // Ideal switch matrix: a pressed key shorts its column to its row when that row is driven low
  always_comb begin
    key_col = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!key_row[r])
        for (int c = 0; c < 4; c++)
          if (mask[r*4+c]) key_col[c] = 1'b0;
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (key_strobe === 1'b1) got_strobe.push_back(int'(key_code));
      if (value_valid === 1'b1) got_vv.push_back(int'(value));
    end
  end

  // Keypad legend, index = row*4 + col
  function automatic int key_at(int idx);
    case (idx)
      0: return 1;   1: return 2;   2: return 3;   3: return 10;
      4: return 4;   5: return 5;   6: return 6;   7: return 11;
      8: return 7;   9: return 8;  10: return 9;  11: return 12;
      12: return 14; 13: return 0;  14: return 15; default: return 13;
    endcase
  endfunction

  function automatic logic [15:0] mask_of(int code);
    logic [15:0] m;
    m = 16'h0;
    for (int i = 0; i < 16; i++) if (key_at(i) == code) m[i] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    m_pressed = 0; m_streak = 0; m_cand = 0; m_keycode = 0;
    m_digits = 0; m_entry = 0; m_value = 0;
  endtask

  task automatic model_accept(int code);
    m_keycode = code;
    exp_strobe.push_back(code);
    if (code <= 9) begin
      if (m_digits < 2) begin
        m_entry = m_entry * 10 + code;
        m_digits++;
      end
    end else if (code == 14) begin
      m_entry = 0; m_digits = 0;
    end else if (code == 15 && m_digits > 0) begin
      m_value = m_entry;
      exp_vv.push_back(m_entry);
      m_entry = 0; m_digits = 0;
    end
  endtask

  // A key is accepted after DEB consecutive frames showing it alone, and released after DEB
  // consecutive frames with no single key; a broken press streak restarts from scratch.
  task automatic model_frame(input logic [15:0] fm, output bit acc);
    int code;
    bit single;
    acc = 0;
    single = ($countones(fm) == 1);
    code = -1;
    for (int i = 0; i < 16; i++) if (fm[i]) code = key_at(i);
    if (m_pressed == 0) begin
      if (single && (m_streak == 0 || code == m_cand)) begin
        m_cand = code;
        m_streak++;
        if (m_streak >= DEB) begin
          m_pressed = 1; m_streak = 0; acc = 1;
          model_accept(code);
        end
      end else begin
        m_streak = 0;
      end
    end else begin
      if (single) m_streak = 0;
      else begin
        m_streak++;
        if (m_streak >= DEB) begin m_pressed = 0; m_streak = 0; end
      end
    end
  endtask

  task automatic run_frame(input logic [15:0] fm);
    mask = fm;
    repeat (FRAME) @(posedge clk);
    #1;
    model_frame(fm, last_acc);
  endtask

  task automatic press(int code, int hold, int rel);
    for (int i = 0; i < hold; i++) run_frame(mask_of(code));
    for (int i = 0; i < rel; i++) run_frame(16'h0);
  endtask

  task automatic test_reset();
    logic [3:0] er;
    mask = 16'h0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    n_checks++;
    if ({key_row, key_code, key_strobe, digit_cnt, value, value_valid} !== {4'b1110, 4'd0, 1'b0, 2'd0, 7'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got row=%b code=%0d stb=%b dc=%0d val=%0d vv=%b required row=1110 rest 0",
               key_row, key_code, key_strobe, digit_cnt, value, value_valid);
    end
    rst = 1'b0;
    for (int n = 0; n < 2 * FRAME; n++) begin
      er = ~(4'b0001 << ((n / SD) % 4));
      n_checks++;
      if (key_row !== er) begin
        n_fail++;
        $display("FAIL scan_row[%0d]: got %b required %b", n, key_row, er);
      end
      if (n == 1) begin
        n_checks++;
        if ({key_code, key_strobe, digit_cnt, value, value_valid} !== 15'd0) begin
          n_fail++;
          $display("FAIL first_cycle_after_reset: got code=%0d stb=%b dc=%0d val=%0d vv=%b required all 0",
                   key_code, key_strobe, digit_cnt, value, value_valid);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_entry_42();
    int codes[3];
    codes = '{4, 2, 15};
    for (int k = 0; k < 3; k++) begin
      press(codes[k], 3, 3);
      n_checks++;
      if (int'(digit_cnt) != m_digits) begin
        n_fail++;
        $display("FAIL entry42_digit_cnt[%0d]: got %0d required %0d", k, digit_cnt, m_digits);
      end
    end
    n_checks++;
    if (int'(value) != m_value) begin
      n_fail++;
      $display("FAIL entry42_value: got %0d required %0d", value, m_value);
    end
    n_checks++;
    if (got_strobe.size() != exp_strobe.size() || got_vv.size() != exp_vv.size()) begin
      n_fail++;
      $display("FAIL entry42_event_count: got strobes=%0d commits=%0d required strobes=%0d commits=%0d",
               got_strobe.size(), got_vv.size(), exp_strobe.size(), exp_vv.size());
    end else begin
      for (int i = 0; i < got_strobe.size(); i++) begin
        n_checks++;
        if (got_strobe[i] != exp_strobe[i]) begin
          n_fail++;
          $display("FAIL entry42_code[%0d]: got %0d required %0d", i, got_strobe[i], exp_strobe[i]);
        end
      end
      for (int i = 0; i < got_vv.size(); i++) begin
        n_checks++;
        if (got_vv[i] != exp_vv[i]) begin
          n_fail++;
          $display("FAIL entry42_commit[%0d]: got %0d required %0d", i, got_vv[i], exp_vv[i]);
        end
      end
    end
    got_strobe.delete(); exp_strobe.delete(); got_vv.delete(); exp_vv.delete();
  endtask

  task automatic test_bounce();
    press(7, 1, 1);
    press(7, 1, 3);
    n_checks++;
    if (got_strobe.size() != 0 || exp_strobe.size() != 0) begin
      n_fail++;
      $display("FAIL bounce_no_strobe: got %0d strobes required %0d", got_strobe.size(), exp_strobe.size());
    end
    press(7, 2, 3);
    n_checks++;
    if (got_strobe.size() != exp_strobe.size()) begin
      n_fail++;
      $display("FAIL bounce_strobe_count: got %0d required %0d", got_strobe.size(), exp_strobe.size());
    end else begin
      for (int i = 0; i < got_strobe.size(); i++) begin
        n_checks++;
        if (got_strobe[i] != exp_strobe[i]) begin
          n_fail++;
          $display("FAIL bounce_code[%0d]: got %0d required %0d", i, got_strobe[i], exp_strobe[i]);
        end
      end
    end
    n_checks++;
    if (int'(digit_cnt) != m_digits) begin
      n_fail++;
      $display("FAIL bounce_digit_cnt: got %0d required %0d", digit_cnt, m_digits);
    end
    got_strobe.delete(); exp_strobe.delete(); got_vv.delete(); exp_vv.delete();
  endtask

  task automatic test_overflow_clear();
    int seq1[5];
    int seq2[3];
    seq1 = '{14, 9, 9, 5, 15};
    seq2 = '{3, 14, 15};
    foreach (seq1[i]) press(seq1[i], 2, 2);
    n_checks++;
    if (int'(value) != m_value || int'(digit_cnt) != m_digits) begin
      n_fail++;
      $display("FAIL overflow_value: got value=%0d dc=%0d required value=%0d dc=%0d", value, digit_cnt, m_value, m_digits);
    end
    foreach (seq2[i]) press(seq2[i], 2, 2);
    n_checks++;
    if (int'(value) != m_value || int'(digit_cnt) != m_digits) begin
      n_fail++;
      $display("FAIL clear_value: got value=%0d dc=%0d required value=%0d dc=%0d", value, digit_cnt, m_value, m_digits);
    end
    n_checks++;
    if (got_vv.size() != exp_vv.size() || got_strobe.size() != exp_strobe.size()) begin
      n_fail++;
      $display("FAIL overflow_event_count: got commits=%0d strobes=%0d required commits=%0d strobes=%0d",
               got_vv.size(), got_strobe.size(), exp_vv.size(), exp_strobe.size());
    end else begin
      for (int i = 0; i < got_vv.size(); i++) begin
        n_checks++;
        if (got_vv[i] != exp_vv[i]) begin
          n_fail++;
          $display("FAIL overflow_commit[%0d]: got %0d required %0d", i, got_vv[i], exp_vv[i]);
        end
      end
    end
    got_strobe.delete(); exp_strobe.delete(); got_vv.delete(); exp_vv.delete();
  endtask

  task automatic test_multi_key();
    for (int i = 0; i < 2; i++) run_frame(mask_of(1) | mask_of(5));
    n_checks++;
    if (got_strobe.size() != 0 || exp_strobe.size() != 0) begin
      n_fail++;
      $display("FAIL multi_no_strobe: got %0d strobes required %0d", got_strobe.size(), exp_strobe.size());
    end
    press(1, 2, 3);
    n_checks++;
    if (got_strobe.size() != exp_strobe.size() || got_strobe.size() == 0) begin
      n_fail++;
      $display("FAIL multi_strobe_count: got %0d required %0d", got_strobe.size(), exp_strobe.size());
    end else if (got_strobe[0] != exp_strobe[0]) begin
      n_fail++;
      $display("FAIL multi_code: got %0d required %0d", got_strobe[0], exp_strobe[0]);
    end
    got_strobe.delete(); exp_strobe.delete(); got_vv.delete(); exp_vv.delete();
  endtask

  task automatic test_reset_mid_press();
    press(3, 2, 2);
    n_checks++;
    if (int'(digit_cnt) != m_digits) begin
      n_fail++;
      $display("FAIL midrst_pre_digit_cnt: got %0d required %0d", digit_cnt, m_digits);
    end
    run_frame(mask_of(8));
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    n_checks++;
    if (digit_cnt !== 2'd0 || key_strobe !== 1'b0 || key_row !== 4'b1110) begin
      n_fail++;
      $display("FAIL midrst_in_reset: got dc=%0d stb=%b row=%b required dc=0 stb=0 row=1110", digit_cnt, key_strobe, key_row);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if (key_row !== 4'b1110 || digit_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL midrst_release: got row=%b dc=%0d required row=1110 dc=0", key_row, digit_cnt);
    end
    got_strobe.delete(); exp_strobe.delete();
    press(8, 1, 3);
    n_checks++;
    if (got_strobe.size() != exp_strobe.size()) begin
      n_fail++;
      $display("FAIL midrst_no_strobe: got %0d strobes required %0d", got_strobe.size(), exp_strobe.size());
    end
    got_strobe.delete(); exp_strobe.delete(); got_vv.delete(); exp_vv.delete();
  endtask

  task automatic test_random();
    int idx, idx2, hold, rel, kind;
    logic [15:0] fm;
    for (int seg = 0; seg < 60; seg++) begin
      kind = $urandom_range(0, 9);
      idx  = $urandom_range(0, 15);
      idx2 = (idx + $urandom_range(1, 15)) % 16;
      hold = $urandom_range(1, 4);
      rel  = $urandom_range(1, 3);
      for (int f = 0; f < hold + rel; f++) begin
        fm = 16'h0;
        if (f < hold) begin
          fm[idx] = 1'b1;
          if (kind < 2) fm[idx2] = 1'b1;
          else if (kind == 2 && f == 1) fm = 16'h0 | (16'h1 << idx2);
        end
        run_frame(fm);
        if (!last_acc) begin
          n_checks++;
          if (int'(digit_cnt) != m_digits || int'(value) != m_value || int'(key_code) != m_keycode) begin
            n_fail++;
            $display("FAIL random_state[%0d.%0d]: got dc=%0d val=%0d code=%0d required dc=%0d val=%0d code=%0d",
                     seg, f, digit_cnt, value, key_code, m_digits, m_value, m_keycode);
          end
        end
      end
    end
    n_checks++;
    if (got_strobe.size() != exp_strobe.size() || got_vv.size() != exp_vv.size()) begin
      n_fail++;
      $display("FAIL random_event_count: got strobes=%0d commits=%0d required strobes=%0d commits=%0d",
               got_strobe.size(), got_vv.size(), exp_strobe.size(), exp_vv.size());
    end else begin
      for (int i = 0; i < got_strobe.size(); i++) begin
        n_checks++;
        if (got_strobe[i] != exp_strobe[i]) begin
          n_fail++;
          $display("FAIL random_code[%0d]: got %0d required %0d", i, got_strobe[i], exp_strobe[i]);
        end
      end
      for (int i = 0; i < got_vv.size(); i++) begin
        n_checks++;
        if (got_vv[i] != exp_vv[i]) begin
          n_fail++;
          $display("FAIL random_commit[%0d]: got %0d required %0d", i, got_vv[i], exp_vv[i]);
        end
      end
    end
    got_strobe.delete(); exp_strobe.delete(); got_vv.delete(); exp_vv.delete();
  endtask

  initial begin
    rst  = 1'b1;
    mask = 16'h0;
    test_reset();
    test_entry_42();
    test_bounce();
    test_overflow_clear();
    test_multi_key();
    test_reset_mid_press();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
